// File: rtl/vram_pkg.sv
// Shared constants and state encodings for the UART-to-VRAM frame loader.
package vram_pkg;

    localparam int         VRAM_WORDS = 75;
    localparam int         VRAM_AW    = 7;
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } load_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_vram_loader_uart_rx.sv
// UART receiver: 2-flop synchronizer, bit timing, byte and error strobes.
// Optional even parity (8E1) when UART_PARITY_EN is defined; 8N1 otherwise.
module uart_rx
    import vram_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       err_o
);

    localparam int             CW      = $clog2(DIV);
    localparam logic [CW-1:0]  HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(DIV - 1);

    // [1:0] synchronizer, [2] previous synchronized value for edge detection
    logic [2:0]    sync_q;
    logic          rx_s;
    rx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          byte_valid_q;
    logic          err_q;
`ifdef UART_PARITY_EN
    logic          par_bad_q;
`endif

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q       <= '1;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad_q    <= 1'b0;
`endif
        end else begin
            sync_q       <= {sync_q[1:0], rx_i};
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (sync_q[2] && !rx_s) begin
                        cnt_q   <= HALF_M1;
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == '0) begin
                        if (rx_s) begin
                            state_q <= RX_IDLE;
                        end else begin
                            cnt_q   <= FULL_M1;
                            bit_q   <= '0;
                            state_q <= RX_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        cnt_q   <= FULL_M1;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_q <= RX_PAR;
`else
                            state_q <= RX_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                RX_PAR: begin
                    if (cnt_q == '0) begin
                        par_bad_q <= rx_s ^ (^shift_q);
                        cnt_q     <= FULL_M1;
                        state_q   <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
`endif
                RX_STOP: begin
                    if (cnt_q == '0) begin
                        state_q <= RX_IDLE;
`ifdef UART_PARITY_EN
                        if (rx_s && !par_bad_q) begin
`else
                        if (rx_s) begin
`endif
                            byte_q       <= shift_q;
                            byte_valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign err_o        = err_q;

endmodule

// File: rtl/uart_vram_loader.sv
// Loads a 75-word frame from a UART byte stream into the video RAM write port.
// Optional UART_PARITY_EN selects 8E1 framing in the receiver.
module uart_vram_loader
    import vram_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BAUD    = 115_200,
    parameter int TIMEOUT = 5_000_000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               uart_rx,
    output logic               we,
    output logic [VRAM_AW-1:0] address,
    output logic [31:0]        data,
    output logic               busy,
    output logic               frame_done,
    output logic               err
);

    // state | meaning
    // IDLE  | waiting for SYNC, all other bytes ignored
    // LOAD  | packing pixel bytes into words, inter-byte timeout armed
    // DONE  | last word written, pulse frame_done for one cycle

    localparam int                 DIV       = CLK_HZ / BAUD;
    localparam int                 TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]      TMO_M1    = TW'(TIMEOUT - 1);
    localparam logic [VRAM_AW-1:0] LAST_WORD = VRAM_AW'(VRAM_WORDS - 1);

    logic [7:0]         rx_byte;
    logic               rx_valid;
    logic               rx_err;
    load_state_e        state_q;
    logic [VRAM_AW-1:0] word_q;
    logic [1:0]         slot_q;
    logic [23:0]        pack_q;
    logic [TW-1:0]      tmo_q;
    logic               we_q;
    logic [VRAM_AW-1:0] addr_q;
    logic [31:0]        data_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    uart_rx #(.DIV(DIV)) u_rx (
        .clk_i        (CLOCK_50),
        .rst_i        (reset),
        .rx_i         (uart_rx),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .err_o        (rx_err)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            slot_q  <= '0;
            pack_q  <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            if (rx_err) err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (rx_valid && rx_byte == SYNC_BYTE) begin
                        word_q  <= '0;
                        slot_q  <= '0;
                        tmo_q   <= TMO_M1;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (rx_valid) begin
                        tmo_q <= TMO_M1;
                        if (slot_q == 2'd3) begin
                            we_q   <= 1'b1;
                            addr_q <= word_q;
                            data_q <= {pack_q, rx_byte};
                            word_q <= word_q + 7'd1;
                            slot_q <= '0;
                            if (word_q == LAST_WORD) begin
                                busy_q  <= 1'b0;
                                state_q <= DONE;
                            end
                        end else begin
                            pack_q <= {pack_q[15:0], rx_byte};
                            slot_q <= slot_q + 2'd1;
                        end
                    end else if (tmo_q == '0) begin
                        // Partial word is abandoned; earlier writes stand.
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q - TW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign we         = we_q;
    assign address    = addr_q;
    assign data       = data_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_uart_vram_loader.sv
// Self-checking bench for uart_vram_loader: serial stimulus, write scoreboard, vector table.
module tb_uart_vram_loader;
    import vram_pkg::*;

    localparam int CLK_HZ  = 600_000;
    localparam int BAUD    = 100_000;
    localparam int DIV     = CLK_HZ / BAUD;
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        we;
    logic [6:0]  address;
    logic [31:0] data;
    logic        busy;
    logic        frame_done;
    logic        err;

    always #5 clk = ~clk;

    uart_vram_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .uart_rx    (rx),
        .we         (we),
        .address    (address),
        .data       (data),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    typedef struct packed {
        logic [6:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [7:0] b;
        bit         stop;
        bit         exp_busy;
        bit         exp_err;
    } vec_t;

    wr_t         exp_q[$];
    vec_t        vt[9];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    int          n_done   = 0;
    logic [31:0] wr_log[0:127];
`ifdef UART_PARITY_EN
    bit          bad_par  = 1'b0;
`endif

    bit          m_load = 1'b0;
    int          m_slot = 0;
    int          m_word = 0;
    logic [23:0] m_pack = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
        end
    endtask

    // Reference behaviour of the loader for one received byte.
    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) return;
        if (!m_load) begin
            if (b == SYNC_BYTE) begin
                m_load = 1'b1;
                m_slot = 0;
                m_word = 0;
            end
        end else if (m_slot == 3) begin
            exp_q.push_back({7'(m_word), m_pack, b});
            m_slot = 0;
            m_word++;
            if (m_word == VRAM_WORDS) m_load = 1'b0;
        end else begin
            m_pack = {m_pack[15:0], b};
            m_slot++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx = (^b) ^ bad_par;
        repeat (DIV) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (stop_bit ? 2 : DIV + 2) @(negedge clk);
    endtask

    task automatic send_model(input logic [7:0] b, input bit stop_bit);
        bit ok;
        ok = stop_bit;
`ifdef UART_PARITY_EN
        if (bad_par) ok = 1'b0;
`endif
        model_byte(b, ok);
        send_byte(b, stop_bit);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_ctrl", {28'b0, we, busy, frame_done, err}, 32'h0);
        check("rst_addr", 32'(address), 32'h0);
        check("rst_data", data, 32'h0);
        exp_q.delete();
        m_load = 1'b0;
        m_slot = 0;
        m_word = 0;
        rx     = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame();
        int base_w;
        int base_d;
        base_w = n_writes;
        base_d = n_done;
        send_model(SYNC_BYTE, 1'b1);
        check("sync_busy", 32'(busy), 32'h1);
        check("sync_err_clear", 32'(err), 32'h0);
        for (int i = 0; i < 300; i++) send_model(8'(i), 1'b1);
        repeat (4) @(negedge clk);
        check("frame_writes", 32'(n_writes - base_w), 32'd75);
        check("frame_done_count", 32'(n_done - base_d), 32'd1);
        check("word0", wr_log[0], 32'h00010203);
        check("word74", wr_log[74], 32'h28292A2B);
        check("frame_busy_low", 32'(busy), 32'h0);
        check("frame_err", 32'(err), 32'h0);
        check("frame_q_empty", 32'(exp_q.size()), 32'h0);
    endtask

    // Write monitor and scoreboard, sampled on the falling edge.
    initial begin
        wr_t         e;
        bit          prev_we = 1'b0;
        logic [6:0]  prev_a  = '0;
        logic [6:0]  hold_a  = '0;
        logic [31:0] hold_d  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_we = 1'b0;
                hold_a  = '0;
                hold_d  = '0;
            end else begin
                if (frame_done) begin
                    n_done++;
                    check("done_after_last_we", {prev_we, 24'b0, prev_a}, {1'b1, 24'b0, 7'd74});
                end
                if (we) begin
                    n_writes++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", address, data);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", 32'(address), 32'(e.a));
                        check("write_data", data, e.d);
                    end
                    wr_log[address] = data;
                    hold_a = address;
                    hold_d = data;
                end else if (prev_we) begin
                    check("hold_addr", 32'(address), 32'(hold_a));
                    check("hold_data", data, hold_d);
                end
                prev_we = we;
                prev_a  = address;
            end
        end
    end

    initial begin
        int base_w;
        bit fired;

        vt[0] = '{8'h12, 1'b1, 1'b0, 1'b0};
        vt[1] = '{8'h34, 1'b1, 1'b0, 1'b0};
        vt[2] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vt[3] = '{8'h11, 1'b1, 1'b1, 1'b0};
        vt[4] = '{8'h22, 1'b0, 1'b1, 1'b1};
        vt[5] = '{8'hA5, 1'b1, 1'b1, 1'b1};
        vt[6] = '{8'h33, 1'b1, 1'b1, 1'b1};
        vt[7] = '{8'h44, 1'b1, 1'b1, 1'b1};
        vt[8] = '{8'h55, 1'b1, 1'b1, 1'b1};

        // Full frame from reset.
        do_reset();
        send_frame();

        // Byte-level table: SYNC filtering, framing error, in-frame 0xA5.
        do_reset();
        base_w = n_writes;
        for (int i = 0; i < 9; i++) begin
            send_model(vt[i].b, vt[i].stop);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].exp_err));
        end
        // One-cycle low glitch must be rejected, not received as a byte.
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        send_model(8'h66, 1'b1);
        send_model(8'h77, 1'b1);
        send_model(8'h88, 1'b1);
        check("vec_writes", 32'(n_writes - base_w), 32'd2);
        check("vec_q_empty", 32'(exp_q.size()), 32'h0);

        // Inter-byte timeout after SYNC + 10 bytes, then a clean frame.
        do_reset();
        base_w = n_writes;
        send_model(SYNC_BYTE, 1'b1);
        for (int i = 0; i < 10; i++) send_model(8'(8'h40 + i), 1'b1);
        repeat (TIMEOUT - 10) @(negedge clk);
        check("tmo_not_early", 32'(busy), 32'h1);
        fired = 1'b0;
        for (int i = 0; i < 40 && !fired; i++) begin
            @(negedge clk);
            if (!busy) fired = 1'b1;
        end
        check("tmo_fired", 32'(fired), 32'h1);
        check("tmo_err", 32'(err), 32'h1);
        check("tmo_writes", 32'(n_writes - base_w), 32'd2);
        check("tmo_q_empty", 32'(exp_q.size()), 32'h0);
        m_load = 1'b0;
        repeat (20) @(negedge clk);
        check("tmo_no_late_write", 32'(n_writes - base_w), 32'd2);
        send_frame();

        // Reset mid-frame after 100 bytes; no writes until a new SYNC.
        do_reset();
        base_w = n_writes;
        send_model(SYNC_BYTE, 1'b1);
        for (int i = 0; i < 100; i++) send_model(8'(i), 1'b1);
        check("pre_rst_writes", 32'(n_writes - base_w), 32'd25);
        do_reset();
        base_w = n_writes;
        for (int i = 0; i < 8; i++) send_model(8'(8'h11 + i), 1'b1);
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_writes", 32'(n_writes - base_w), 32'd0);
        send_model(SYNC_BYTE, 1'b1);
        check("post_rst_sync_busy", 32'(busy), 32'h1);

`ifdef UART_PARITY_EN
        // Wrong parity drops the byte and sets err; correct parity is accepted.
        do_reset();
        base_w = n_writes;
        send_model(SYNC_BYTE, 1'b1);
        bad_par = 1'b1;
        send_model(8'h03, 1'b1);
        bad_par = 1'b0;
        check("par_bad_err", 32'(err), 32'h1);
        send_model(8'h03, 1'b1);
        send_model(8'h04, 1'b1);
        send_model(8'h05, 1'b1);
        send_model(8'h06, 1'b1);
        check("par_writes", 32'(n_writes - base_w), 32'd1);
        check("par_word", wr_log[0], 32'h03040506);
        check("par_q_empty", 32'(exp_q.size()), 32'h0);
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
